curve_uop_sequencer: RTL and testbench

Microcode sequencer for the ECDSA curve point engine. On a start pulse it walks a synchronous uop ROM from address 0:
- decodes each 20-bit word;
- filters it by its execution condition;
- issues it to the modular-arithmetic datapath over a request/ready handshake;
- stops at the first OPCODE_RDY word.

It sits directly downstream of the init/double/add uop ROMs and drives their address inputs.

---
 rtl/uop_ecdsa_pkg.sv | 70 +++++++
 rtl/curve_uop_seq_watchdog.sv | 28 ++
 rtl/curve_uop_sequencer.sv | 135 +++++++++++++
 tb/tb_curve_uop_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uop_ecdsa_pkg.sv
// uop_ecdsa_pkg: constants shared by the ECDSA uop ROMs, the sequencer
// and the modular-arithmetic datapath (word layout, opcodes, selects).
package uop_ecdsa_pkg;

    localparam int UOP_W = 20;

    // Word layout: [19:16] opcode, [15:11] src A, [10:6] src B,
    // [5:2] dst, [1:0] exec.
    typedef struct packed {
        logic [3:0] opcode;
        logic [4:0] src_a;
        logic [4:0] src_b;
        logic [3:0] dst;
        logic [1:0] exec;
    } uop_word_t;

    localparam logic [3:0] OPCODE_NOP = 4'h0;
    localparam logic [3:0] OPCODE_MOV = 4'h1;
    localparam logic [3:0] OPCODE_ADD = 4'h2;
    localparam logic [3:0] OPCODE_SUB = 4'h3;
    localparam logic [3:0] OPCODE_MUL = 4'h4;
    localparam logic [3:0] OPCODE_SQR = 4'h5;
    localparam logic [3:0] OPCODE_INV = 4'h6;
    localparam logic [3:0] OPCODE_RDY = 4'hF;

    localparam logic [1:0] EXEC_ALWAYS = 2'b00;
    localparam logic [1:0] EXEC_IF_SET = 2'b01;
    localparam logic [1:0] EXEC_IF_CLR = 2'b10;
    localparam logic [1:0] EXEC_RSVD   = 2'b11;

    localparam logic [4:0] SRC_ZERO = 5'd0;
    localparam logic [4:0] SRC_ONE  = 5'd1;

    localparam logic [3:0] DST_RX = 4'd1;
    localparam logic [3:0] DST_RY = 4'd2;
    localparam logic [3:0] DST_RZ = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    function automatic logic exec_taken(
        input logic [1:0] exec,
        input logic       c
    );
        logic t;
        unique case (exec)
            EXEC_ALWAYS: t = 1'b1;
            EXEC_IF_SET: t = c;
            EXEC_IF_CLR: t = !c;
            default:     t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic [UOP_W-1:0] uop_pack(
        input logic [3:0] opc,
        input logic [4:0] a,
        input logic [4:0] b,
        input logic [3:0] d,
        input logic [1:0] x
    );
        return {opc, a, b, d, x};
    endfunction

endpackage

// File: rtl/curve_uop_seq_watchdog.sv
// curve_uop_seq_watchdog: EXEC-stall counter with all-ones expiry.
// Ports: clk, rst (sync, high), clr, inc, expired.
module curve_uop_seq_watchdog #(
    parameter int WDOG_W = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [WDOG_W-1:0] cnt;

    assign expired = &cnt;

    // Saturates at all-ones so a held expiry never wraps back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/curve_uop_sequencer.sv
// curve_uop_sequencer: walks the uop ROM from address 0 on ena, filters
// words by exec condition, issues them to the datapath, stops at RDY.
// Ports: clk, rst (sync, high), ena, cond, rdy, uop_addr, uop_data,
//   op_ena, op_code, op_src_a, op_src_b, op_dst, op_rdy, err.
// Option: CURVE_UOP_SEQ_WATCHDOG_EN adds an EXEC stall abort (err).
module curve_uop_sequencer
    import uop_ecdsa_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int WDOG_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    output logic              rdy,
    input  logic              cond,
    output logic [ADDR_W-1:0] uop_addr,
    input  logic [UOP_W-1:0]  uop_data,
    output logic              op_ena,
    output logic [3:0]        op_code,
    output logic [4:0]        op_src_a,
    output logic [4:0]        op_src_b,
    output logic [3:0]        op_dst,
    input  logic              op_rdy,
    output logic              err
);

    seq_state_e state;
    logic       cond_r;
    uop_word_t  word;
    logic       last_addr;
    logic       wdog_expired;

    assign word      = uop_data;
    assign last_addr = &uop_addr;

    if (WDOG_W < 1) begin : g_wdog_w_check
        $error("WDOG_W must be at least 1");
    end

`ifdef CURVE_UOP_SEQ_WATCHDOG_EN
    curve_uop_seq_watchdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (op_ena),
        .inc     (state == ST_EXEC),
        .expired (wdog_expired)
    );
`else
    assign wdog_expired = 1'b0;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rdy      <= 1'b1;
            cond_r   <= 1'b0;
            uop_addr <= '0;
            op_ena   <= 1'b0;
            op_code  <= '0;
            op_src_a <= '0;
            op_src_b <= '0;
            op_dst   <= '0;
`ifdef CURVE_UOP_SEQ_WATCHDOG_EN
            err      <= 1'b0;
`endif
        end else begin
            op_ena <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (ena) begin
                        cond_r   <= cond;
                        uop_addr <= '0;
                        rdy      <= 1'b0;
                        state    <= ST_FETCH;
`ifdef CURVE_UOP_SEQ_WATCHDOG_EN
                        err      <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (word.opcode == OPCODE_RDY) begin
                        state <= ST_DONE;
                    end else if (!exec_taken(word.exec, cond_r)) begin
                        // The top address ends the run instead of wrapping.
                        if (last_addr) begin
                            state <= ST_DONE;
                        end else begin
                            uop_addr <= uop_addr + 1'b1;
                            state    <= ST_FETCH;
                        end
                    end else begin
                        op_code  <= word.opcode;
                        op_src_a <= word.src_a;
                        op_src_b <= word.src_b;
                        op_dst   <= word.dst;
                        op_ena   <= 1'b1;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // op_rdy alongside our own request is not a completion.
                    if (op_rdy && !op_ena) begin
                        if (last_addr) begin
                            state <= ST_DONE;
                        end else begin
                            uop_addr <= uop_addr + 1'b1;
                            state    <= ST_FETCH;
                        end
                    end else if (wdog_expired && !op_ena) begin
`ifdef CURVE_UOP_SEQ_WATCHDOG_EN
                        err   <= 1'b1;
`endif
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rdy      <= 1'b1;
                    uop_addr <= '0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_curve_uop_sequencer.sv
// tb_curve_uop_sequencer: directed checks of the uop sequencer against
// a bench ROM and a fixed-latency datapath model.
module tb_curve_uop_sequencer;
    import uop_ecdsa_pkg::*;

    localparam int ADDR_W = 6;
    localparam int WDOG_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ena = 1'b0;
    logic              cond = 1'b0;
    logic              rdy;
    logic [ADDR_W-1:0] uop_addr;
    logic [UOP_W-1:0]  uop_data;
    logic              op_ena;
    logic [3:0]        op_code;
    logic [4:0]        op_src_a;
    logic [4:0]        op_src_b;
    logic [3:0]        op_dst;
    logic              op_rdy;
    logic              err;

    curve_uop_sequencer #(
        .ADDR_W (ADDR_W),
        .WDOG_W (WDOG_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .rdy      (rdy),
        .cond     (cond),
        .uop_addr (uop_addr),
        .uop_data (uop_data),
        .op_ena   (op_ena),
        .op_code  (op_code),
        .op_src_a (op_src_a),
        .op_src_b (op_src_b),
        .op_dst   (op_dst),
        .op_rdy   (op_rdy),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [UOP_W-1:0] rom [64];
    always @(posedge clk) uop_data <= rom[uop_addr];

    // Datapath: op_rdy 'lat' cycles after op_ena; 'inj' also raises
    // op_rdy in the op_ena cycle itself, which must be ignored.
    logic [7:0] pipe = '0;
    int         lat = 3;
    bit         dp_on = 1'b1;
    bit         inj = 1'b0;
    always @(posedge clk) pipe <= {pipe[6:0], op_ena};
    assign op_rdy = (dp_on & pipe[lat-1]) | (inj & op_ena);

    typedef struct {
        logic [3:0] code;
        logic [3:0] dst;
        int         cyc;
    } issue_t;

    issue_t log_q[$];
    issue_t mon_it;
    int     cyc = 0;
    int     acc = 0;
    int     errors = 0;
    int     checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (op_ena) begin
            mon_it.code = op_code;
            mon_it.dst  = op_dst;
            mon_it.cyc  = cyc;
            log_q.push_back(mon_it);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dst_at(input int i);
        return (i < log_q.size()) ? int'(log_q[i].dst) : -1;
    endfunction

    function automatic int code_at(input int i);
        return (i < log_q.size()) ? int'(log_q[i].code) : -1;
    endfunction

    function automatic int off_at(input int i);
        return (i < log_q.size()) ? log_q[i].cyc - acc : -1;
    endfunction

    // Pulse ena with cond=c, then count edges until rdy is back.
    // disturb: re-pulse ena and flip cond while the first uop executes.
    task automatic run(input bit c, input bit disturb,
                       output int n, output int wraps);
        int prev;
        log_q.delete();
        n = 0;
        wraps = 0;
        prev = 0;
        @(negedge clk);
        ena  = 1'b1;
        cond = c;
        @(posedge clk);
        #1;
        acc = cyc;
        ena = 1'b0;
        while (n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (disturb && n == 4) begin
                ena  = 1'b1;
                cond = !c;
            end
            if (disturb && n == 5) ena = 1'b0;
            if (rdy) break;
            if (uop_addr < prev) wraps++;
            prev = int'(uop_addr);
        end
        check("run_done", rdy, 1);
    endtask

    task automatic load_init();
        for (int i = 0; i < 64; i++)
            rom[i] = uop_pack(OPCODE_RDY, 0, 0, 0, EXEC_ALWAYS);
        rom[0] = uop_pack(OPCODE_MOV, SRC_ONE, 0, DST_RX, EXEC_ALWAYS);
        rom[1] = uop_pack(OPCODE_MOV, SRC_ONE, 0, DST_RY, EXEC_ALWAYS);
        rom[2] = uop_pack(OPCODE_MOV, SRC_ZERO, 0, DST_RZ, EXEC_ALWAYS);
    endtask

    task automatic load_cond();
        for (int i = 0; i < 64; i++)
            rom[i] = uop_pack(OPCODE_RDY, 0, 0, 0, EXEC_ALWAYS);
        rom[0] = uop_pack(OPCODE_ADD, 5'd2, 5'd3, 4'd5, EXEC_IF_SET);
        rom[1] = uop_pack(OPCODE_SUB, 5'd2, 5'd3, 4'd6, EXEC_IF_CLR);
        rom[2] = uop_pack(OPCODE_MUL, 5'd4, 5'd4, 4'd7, EXEC_ALWAYS);
    endtask

    initial begin
        int n;
        int w;

        load_init();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", rdy, 1);
        check("rst_addr", uop_addr, 0);
        check("rst_op_ena", op_ena, 0);
        check("rst_op_code", op_code, 0);
        check("rst_src_a", op_src_a, 0);
        check("rst_src_b", op_src_b, 0);
        check("rst_dst", op_dst, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Init program, latency 3: 3 x 6 cycles, then FETCH/DECODE/DONE.
        run(1'b1, 1'b0, n, w);
        check("init_cycles", n, 21);
        check("init_count", log_q.size(), 3);
        check("init_dst0", dst_at(0), DST_RX);
        check("init_dst1", dst_at(1), DST_RY);
        check("init_dst2", dst_at(2), DST_RZ);
        check("init_code2", code_at(2), OPCODE_MOV);
        check("init_off0", off_at(0), 2);
        check("init_off1", off_at(1), 8);
        check("init_off2", off_at(2), 14);
        check("init_hold_dst", op_dst, DST_RZ);
        check("init_hold_src_a", op_src_a, SRC_ZERO);
        check("init_addr_end", uop_addr, 0);

        // Latency 1 plus stray op_rdy in the op_ena cycle.
        lat = 1;
        inj = 1'b1;
        run(1'b0, 1'b0, n, w);
        check("lat1_cycles", n, 15);
        check("lat1_count", log_q.size(), 3);
        check("lat1_off1", off_at(1), 6);
        check("lat1_off2", off_at(2), 10);
        lat = 3;
        inj = 1'b0;

        // Condition filtering.
        load_cond();
        run(1'b1, 1'b0, n, w);
        check("cset_cycles", n, 17);
        check("cset_count", log_q.size(), 2);
        check("cset_code0", code_at(0), OPCODE_ADD);
        check("cset_code1", code_at(1), OPCODE_MUL);
        run(1'b0, 1'b0, n, w);
        check("cclr_cycles", n, 17);
        check("cclr_count", log_q.size(), 2);
        check("cclr_code0", code_at(0), OPCODE_SUB);
        check("cclr_dst1", dst_at(1), 7);

        // ena and cond disturbed during EXEC.
        run(1'b1, 1'b1, n, w);
        check("dist_cycles", n, 17);
        check("dist_count", log_q.size(), 2);
        check("dist_dst0", dst_at(0), 5);
        check("dist_dst1", dst_at(1), 7);

        // No RDY, everything reserved: full sweep, no wrap.
        for (int i = 0; i < 64; i++)
            rom[i] = uop_pack(OPCODE_MOV, SRC_ONE, 0, DST_RX, EXEC_RSVD);
        run(1'b1, 1'b0, n, w);
        check("sweep_cycles", n, 129);
        check("sweep_count", log_q.size(), 0);
        check("sweep_wraps", w, 0);
        check("sweep_addr_end", uop_addr, 0);

        // Only the top word executes, then DONE without wrapping.
        rom[63] = uop_pack(OPCODE_SQR, 5'd6, 5'd6, 4'd9, EXEC_ALWAYS);
        run(1'b0, 1'b0, n, w);
        check("top_cycles", n, 133);
        check("top_count", log_q.size(), 1);
        check("top_dst", dst_at(0), 9);
        check("top_off", off_at(0), 128);
        check("top_wraps", w, 0);

        // Reset while executing.
        load_init();
        @(negedge clk);
        ena  = 1'b1;
        cond = 1'b1;
        @(posedge clk);
        #1;
        ena = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_op_ena", op_ena, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_rdy", rdy, 1);
        check("mid_rst_op_ena", op_ena, 0);
        check("mid_rst_addr", uop_addr, 0);
        check("mid_rst_code", op_code, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run(1'b1, 1'b0, n, w);
        check("restart_cycles", n, 21);
        check("restart_count", log_q.size(), 3);
        check("restart_dst0", dst_at(0), DST_RX);

`ifdef CURVE_UOP_SEQ_WATCHDOG_EN
        dp_on = 1'b0;
        run(1'b1, 1'b0, n, w);
        check("wdog_cycles", n, 20);
        check("wdog_err", err, 1);
        check("wdog_count", log_q.size(), 1);
        dp_on = 1'b1;
        run(1'b1, 1'b0, n, w);
        check("wdog_clr_err", err, 0);
        check("wdog_clr_cycles", n, 21);
`else
        check("no_wdog_err", err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
